// File: rtl/sc_layer_scheduler.sv
// -----------------------------------------------------------------------------
// sc_layer_scheduler
// Sequential per-bit layer scheduler for an SC polar decoder of length
// N = 2^LOG_N. For each bit index i it walks the decoding tree from the start
// layer (LOG_N when i==0, else ctz(i)) down to layer 0. It issues one step per
// layer to the PE array. After the layer-0 step it waits for the hard
// decision of bit i.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   frame_start     begin a frame (sampled only while idle)
//   frame_abort     drop the current frame (any state, highest priority)
//   step_valid/step_ready           step handshake towards the PE array
//   step_layer/op/src_addr/dst_addr/len   step payload (layer t, f/g, bases, 2^t)
//   bit_req/bit_done                hard-decision handshake for bit_idx
//   bit_idx, start_layer            current bit index and its start layer
//   busy, frame_done                activity flag, end-of-frame pulse
// -----------------------------------------------------------------------------
module sc_layer_scheduler #(
    parameter int unsigned LOG_N       = 10,
    parameter int unsigned ADDR_WIDTH  = LOG_N + 1,
    parameter int unsigned LAYER_WIDTH = $clog2(LOG_N + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   frame_abort,
    output logic                   step_valid,
    input  logic                   step_ready,
    output logic [LAYER_WIDTH-1:0] step_layer,
    output logic                   step_op,
    output logic [ADDR_WIDTH-1:0]  step_src_addr,
    output logic [ADDR_WIDTH-1:0]  step_dst_addr,
    output logic [LOG_N-1:0]       step_len,
    output logic                   bit_req,
    input  logic                   bit_done,
    output logic [LOG_N-1:0]       bit_idx,
    output logic [LAYER_WIDTH-1:0] start_layer,
    output logic                   busy,
    output logic                   frame_done
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_STEP     = 2'd1,
        S_WAIT_BIT = 2'd2
    } state_t;

    // Base address of layer l: all-ones shifted left by l+1 (layer LOG_N at 0).
    function automatic logic [ADDR_WIDTH-1:0] f_addr(input int unsigned l);
        logic [ADDR_WIDTH-1:0] ones;
        ones = '1;
        return ones << (l + 1);
    endfunction

    // Trailing zeros of v; all-zero input yields LOG_N, i.e. the i==0 start layer.
    function automatic logic [LAYER_WIDTH-1:0] f_ctz(input logic [LOG_N-1:0] v);
        logic [LAYER_WIDTH-1:0] r;
        r = LAYER_WIDTH'(LOG_N);
        for (int k = int'(LOG_N) - 1; k >= 0; k--) begin
            if (v[k]) r = LAYER_WIDTH'(k);
        end
        return r;
    endfunction

    // Number of PE ops for layer t.
    function automatic logic [LOG_N-1:0] f_len(input logic [LAYER_WIDTH-1:0] t);
        logic [LOG_N-1:0] one;
        one = LOG_N'(1);
        return one << t;
    endfunction

    state_t                 r_state,       w_nxt_state;
    logic                   r_step_valid,  w_nxt_step_valid;
    logic [LAYER_WIDTH-1:0] r_step_layer,  w_nxt_step_layer;
    logic                   r_step_op,     w_nxt_step_op;
    logic [ADDR_WIDTH-1:0]  r_src_addr,    w_nxt_src_addr;
    logic [ADDR_WIDTH-1:0]  r_dst_addr,    w_nxt_dst_addr;
    logic [LOG_N-1:0]       r_step_len,    w_nxt_step_len;
    logic                   r_bit_req,     w_nxt_bit_req;
    logic [LOG_N-1:0]       r_bit_idx,     w_nxt_bit_idx;
    logic [LAYER_WIDTH-1:0] r_start_layer, w_nxt_start_layer;
    logic                   r_busy,        w_nxt_busy;
    logic                   r_frame_done,  w_nxt_frame_done;

    logic                   w_load;
    logic [LAYER_WIDTH-1:0] w_ld_layer;
    logic                   w_ld_op;
    logic                   w_xfer;
    logic [LOG_N-1:0]       w_bit_inc;

    assign w_xfer    = r_step_valid && step_ready;
    assign w_bit_inc = r_bit_idx + LOG_N'(1);

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_step_valid  <= 1'b0;
            r_step_layer  <= '0;
            r_step_op     <= 1'b0;
            r_src_addr    <= '0;
            r_dst_addr    <= '0;
            r_step_len    <= '0;
            r_bit_req     <= 1'b0;
            r_bit_idx     <= '0;
            r_start_layer <= LAYER_WIDTH'(LOG_N);
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_step_valid  <= w_nxt_step_valid;
            r_step_layer  <= w_nxt_step_layer;
            r_step_op     <= w_nxt_step_op;
            r_src_addr    <= w_nxt_src_addr;
            r_dst_addr    <= w_nxt_dst_addr;
            r_step_len    <= w_nxt_step_len;
            r_bit_req     <= w_nxt_bit_req;
            r_bit_idx     <= w_nxt_bit_idx;
            r_start_layer <= w_nxt_start_layer;
            r_busy        <= w_nxt_busy;
            r_frame_done  <= w_nxt_frame_done;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_step_valid  = r_step_valid;
        w_nxt_step_layer  = r_step_layer;
        w_nxt_step_op     = r_step_op;
        w_nxt_src_addr    = r_src_addr;
        w_nxt_dst_addr    = r_dst_addr;
        w_nxt_step_len    = r_step_len;
        w_nxt_bit_req     = r_bit_req;
        w_nxt_bit_idx     = r_bit_idx;
        w_nxt_start_layer = r_start_layer;
        w_nxt_frame_done  = 1'b0;
        w_load            = 1'b0;
        w_ld_layer        = '0;
        w_ld_op           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_nxt_state       = S_STEP;
                    w_nxt_bit_idx     = '0;
                    w_nxt_start_layer = LAYER_WIDTH'(LOG_N);
                    w_nxt_step_valid  = 1'b1;
                    w_load            = 1'b1;
                    w_ld_layer        = LAYER_WIDTH'(LOG_N - 1);
                    w_ld_op           = 1'b0;
                end
            end
            S_STEP: begin
                if (w_xfer) begin
                    if (r_step_layer == '0) begin
                        w_nxt_state      = S_WAIT_BIT;
                        w_nxt_step_valid = 1'b0;
                        w_nxt_bit_req    = 1'b1;
                    end else begin
                        w_load     = 1'b1;
                        w_ld_layer = r_step_layer - LAYER_WIDTH'(1);
                        w_ld_op    = 1'b0;
                    end
                end
            end
            S_WAIT_BIT: begin
                if (bit_done) begin
                    w_nxt_bit_req = 1'b0;
                    if (&r_bit_idx) begin
                        // Last bit of the frame: N-1 detected explicitly, no wrap.
                        w_nxt_state      = S_IDLE;
                        w_nxt_frame_done = 1'b1;
                    end else begin
                        w_nxt_state       = S_STEP;
                        w_nxt_bit_idx     = w_bit_inc;
                        w_nxt_start_layer = f_ctz(w_bit_inc);
                        w_nxt_step_valid  = 1'b1;
                        w_load            = 1'b1;
                        w_ld_layer        = f_ctz(w_bit_inc);
                        w_ld_op           = 1'b1;
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        // Abort overrides any concurrent transfer, decision or start.
        if (frame_abort) begin
            w_nxt_state       = S_IDLE;
            w_nxt_step_valid  = 1'b0;
            w_nxt_bit_req     = 1'b0;
            w_nxt_frame_done  = 1'b0;
            w_nxt_bit_idx     = r_bit_idx;
            w_nxt_start_layer = r_start_layer;
            w_load            = 1'b0;
        end

        if (w_load) begin
            w_nxt_step_layer = w_ld_layer;
            w_nxt_step_op    = w_ld_op;
            w_nxt_src_addr   = f_addr(32'(w_ld_layer) + 1);
            w_nxt_dst_addr   = f_addr(32'(w_ld_layer));
            w_nxt_step_len   = f_len(w_ld_layer);
        end

        w_nxt_busy = (w_nxt_state != S_IDLE);
    end

    assign step_valid    = r_step_valid;
    assign step_layer    = r_step_layer;
    assign step_op       = r_step_op;
    assign step_src_addr = r_src_addr;
    assign step_dst_addr = r_dst_addr;
    assign step_len      = r_step_len;
    assign bit_req       = r_bit_req;
    assign bit_idx       = r_bit_idx;
    assign start_layer   = r_start_layer;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_sc_layer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sc_layer_scheduler
// Self-checking bench: a LOG_N=3 instance exercises full frames, backpressure,
// ignored inputs, abort and reset; a LOG_N=10 instance checks bit 512.
// Expected steps come from a list-based model of the decoding tree.
// -----------------------------------------------------------------------------
module tb_sc_layer_scheduler;

    typedef struct {
        int i;
        int sl;
        int t;
        int op;
        int src;
        int dst;
        int len;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance (LOG_N = 3)
    logic       rst, fs, fa, rdy, bd;
    logic       sv, sop, sbreq, sbusy, sfd;
    logic [1:0] slayer, sstart;
    logic [3:0] ssrc, sdst;
    logic [2:0] slen, sidx;

    // Large instance (LOG_N = 10)
    logic       b_fs, b_fa, b_rdy, b_bd;
    logic       bv, bop, bbreq, bbusy, bfd;
    logic [3:0] blayer, bstart;
    logic [10:0] bsrc, bdst;
    logic [9:0] blen, bidx;

    sc_layer_scheduler #(.LOG_N(3)) u_small (
        .clk(clk), .rst(rst), .frame_start(fs), .frame_abort(fa),
        .step_valid(sv), .step_ready(rdy), .step_layer(slayer), .step_op(sop),
        .step_src_addr(ssrc), .step_dst_addr(sdst), .step_len(slen),
        .bit_req(sbreq), .bit_done(bd), .bit_idx(sidx), .start_layer(sstart),
        .busy(sbusy), .frame_done(sfd)
    );

    sc_layer_scheduler #(.LOG_N(10)) u_big (
        .clk(clk), .rst(rst), .frame_start(b_fs), .frame_abort(b_fa),
        .step_valid(bv), .step_ready(b_rdy), .step_layer(blayer), .step_op(bop),
        .step_src_addr(bsrc), .step_dst_addr(bdst), .step_len(blen),
        .bit_req(bbreq), .bit_done(b_bd), .bit_idx(bidx), .start_layer(bstart),
        .busy(bbusy), .frame_done(bfd)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ctz(input int v);
        int c = 0;
        while (((v >> c) & 1) == 0) c++;
        return c;
    endfunction

    // Layer l sits after all wider layers: base = 2^(L+1) - 2^(l+1).
    function automatic step_t mk(input int logn, input int i, input int t, input int op);
        step_t s;
        s.i   = i;
        s.sl  = (i == 0) ? logn : ctz(i);
        s.t   = t;
        s.op  = op;
        s.src = (1 << (logn + 1)) - (1 << (t + 2));
        s.dst = (1 << (logn + 1)) - (1 << (t + 1));
        s.len = 1 << t;
        return s;
    endfunction

    function automatic logic [31:0] pk(input step_t s);
        return {8'(s.i), 4'(s.sl), 4'(s.t), 4'(s.op), 4'(s.src), 4'(s.dst), 4'(s.len)};
    endfunction

    function automatic logic [31:0] obs_small();
        return {8'(sidx), 4'(sstart), 4'(slayer), 4'(sop), 4'(ssrc), 4'(sdst), 4'(slen)};
    endfunction

    task automatic chk_reset_small();
        chk("rst_ctl", 32'({sv, sbreq, sbusy, sfd}), 32'd0);
        chk("rst_fields", obs_small(), 32'h0030_0000);
    endtask

    // Runs one LOG_N=3 frame. abort_i / rst_i >= 0 cut the frame at that bit.
    task automatic run_frame(input int rdy_pct, input bit noise, input int abort_i, input int rst_i);
        step_t q[$];
        step_t e;
        logic [31:0] held;
        bit stalled = 1'b0;
        bit done    = 1'b0;
        int cyc     = 0;

        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                for (int t = 2; t >= 0; t--) q.push_back(mk(3, 0, t, 0));
            end else begin
                q.push_back(mk(3, i, ctz(i), 1));
                for (int t = ctz(i) - 1; t >= 0; t--) q.push_back(mk(3, i, t, 0));
            end
        end

        @(negedge clk);
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        while (!done && cyc < 400) begin
            cyc++;
            rdy = 1'b0; bd = 1'b0; fs = 1'b0; fa = 1'b0;
            if (sfd) begin
                chk("frame_done_q_empty", 32'(q.size()), 32'd0);
                chk("busy_at_done", 32'(sbusy), 32'd0);
                done = 1'b1;
                @(negedge clk);
                chk("frame_done_pulse", 32'(sfd), 32'd0);
            end else if (sv) begin
                if (stalled) chk("stall_hold", obs_small(), held);
                if (int'(sidx) == abort_i) begin
                    rdy = 1'b1; fa = 1'b1;
                    @(negedge clk);
                    rdy = 1'b0; fa = 1'b0;
                    chk("abort_busy", 32'(sbusy), 32'd0);
                    chk("abort_valid", 32'(sv), 32'd0);
                    for (int k = 0; k < 3; k++) begin
                        chk("abort_no_done", 32'(sfd), 32'd0);
                        @(negedge clk);
                    end
                    done = 1'b1;
                end else begin
                    rdy = ($urandom_range(99) < 32'(rdy_pct));
                    if (rdy) begin
                        if (q.size() == 0) begin
                            chk("extra_step", 32'd1, 32'd0);
                        end else begin
                            e = q.pop_front();
                            chk("step", obs_small(), pk(e));
                            case (slayer)
                                2'd0: chk("dst_t0", 32'(sdst), 32'hE);
                                2'd1: chk("dst_t1", 32'(sdst), 32'hC);
                                default: chk("dst_t2", 32'(sdst), 32'h8);
                            endcase
                        end
                    end
                    stalled = !rdy;
                    held    = obs_small();
                    if (noise && $urandom_range(1) == 1) begin
                        bd = 1'b1; fs = 1'b1;
                    end
                end
            end else if (sbreq) begin
                stalled = 1'b0;
                if (int'(sidx) == rst_i) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk_reset_small();
                    done = 1'b1;
                end else begin
                    bd = 1'b1;
                    if (noise) fs = 1'($urandom_range(1));
                end
            end
            if (!done) @(negedge clk);
        end
        if (!done) chk("frame_timeout", 32'd0, 32'd1);
        rdy = 1'b0; bd = 1'b0; fs = 1'b0; fa = 1'b0;
        @(negedge clk);
    endtask

    // Runs the LOG_N=10 instance up to bit 512 and checks its ten steps.
    task automatic run_big();
        step_t e;
        int k    = 0;
        int cyc  = 0;
        bit done = 1'b0;

        @(negedge clk);
        b_fs = 1'b1;
        @(negedge clk);
        b_fs = 1'b0;
        b_rdy = 1'b1;
        while (!done && cyc < 5000) begin
            cyc++;
            b_bd = 1'b0;
            if (bv && bidx == 10'd512) begin
                e = mk(10, 512, 9 - k, (k == 0) ? 1 : 0);
                if (k == 0) begin
                    chk("b512_start_layer", 32'(bstart), 32'd9);
                    chk("b512_first_src", 32'(bsrc), 32'h000);
                    chk("b512_first_dst", 32'(bdst), 32'h400);
                    chk("b512_first_len", 32'(blen), 32'd512);
                end
                chk("b512_layer", 32'(blayer), 32'(e.t));
                chk("b512_op", 32'(bop), 32'(e.op));
                chk("b512_src", 32'(bsrc), 32'(e.src));
                chk("b512_dst", 32'(bdst), 32'(e.dst));
                chk("b512_len", 32'(blen), 32'(e.len));
                if (k == 9) chk("b512_last_dst", 32'(bdst), 32'h7FE);
                k++;
            end else if (bbreq) begin
                if (bidx == 10'd512) begin
                    chk("b512_step_count", 32'(k), 32'd10);
                    b_fa = 1'b1;
                    @(negedge clk);
                    b_fa = 1'b0;
                    chk("b_abort_busy", 32'(bbusy), 32'd0);
                    done = 1'b1;
                end else begin
                    b_bd = 1'b1;
                end
            end
            if (!done) @(negedge clk);
        end
        if (!done) chk("big_timeout", 32'd0, 32'd1);
        b_rdy = 1'b0; b_bd = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fs = 1'b0; fa = 1'b0; rdy = 1'b0; bd = 1'b0;
        b_fs = 1'b0; b_fa = 1'b0; b_rdy = 1'b0; b_bd = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_small();
        chk("b_rst_start_layer", 32'(bstart), 32'd10);
        rst = 1'b0;
        @(negedge clk);

        run_frame(100, 1'b0, -1, -1);   // full-rate frame
        run_frame(50,  1'b0, -1, -1);   // backpressure
        run_frame(60,  1'b1, -1, -1);   // ignored frame_start / bit_done
        run_frame(100, 1'b0,  5, -1);   // abort with concurrent transfer at i=5
        run_frame(100, 1'b0, -1, -1);   // restart after abort
        run_frame(70,  1'b0, -1,  2);   // reset while waiting on bit 2
        run_frame(100, 1'b0, -1, -1);   // restart after reset
        run_big();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
